// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART blocks.
//   - state encoding for the transmitter FSM
//   - MAX_DATA_BITS, the widest supported payload
//   - clamp_bits(): maps an amountBits request onto the legal 1..8 range
package uart_pkg;

  localparam int unsigned MAX_DATA_BITS = 8;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WAIT_CTS = 3'd1;
  localparam logic [2:0] ST_START    = 3'd2;
  localparam logic [2:0] ST_DATA     = 3'd3;
  localparam logic [2:0] ST_PARITY   = 3'd4;
  localparam logic [2:0] ST_STOP     = 3'd5;

  typedef enum logic [2:0] {
    IDLE     = ST_IDLE,
    WAIT_CTS = ST_WAIT_CTS,
    START    = ST_START,
    DATA     = ST_DATA,
    PARITY   = ST_PARITY,
    STOP     = ST_STOP
  } uart_state_e;

  // 0 or anything above MAX_DATA_BITS selects a full byte.
  function automatic logic [3:0] clamp_bits(input logic [3:0] amt);
    if (amt == 4'd0 || amt > 4'(MAX_DATA_BITS)) begin
      return 4'(MAX_DATA_BITS);
    end
    return amt;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period down-counter for the UART transmitter.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   clear     - restart a full bit period (frame start)
//   tick      - high in the last cycle of each bit period
//   pre_tick  - high one cycle before tick (never high when CLKS_PER_BIT=1)
module uart_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick,
  output logic pre_tick
);

  localparam int unsigned CNT_W  = 16;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;

  // Reload on clear or at every bit boundary, otherwise count down.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear || cnt_q == '0) begin
      cnt_q <= RELOAD;
    end else begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign tick     = (cnt_q == '0);
  assign pre_tick = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/uart_tx.sv
// uart_tx: configurable UART transmitter (start, 1-8 data bits LSB first,
// optional parity, one or two stop bits, optional CTS gating).
// Build option: define UART_TX_PARITY_EN to build the parity bit logic;
// without it parity/even are ignored and no PARITY state is reachable.
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   start                - request a frame (taken only while busy=0)
//   data, amountBits     - payload and its width (0 or >8 means 8)
//   parity, even, stop   - parity enable, even/odd select, two stop bits
//   handshake, cts       - gate frame start on cts when handshake=1
//   tx, busy, done       - serial line, frame in progress, end-of-frame pulse
// The last cycle of the final stop bit is spent in IDLE with done=1 and
// busy=0, so a start in that cycle follows the frame with no extra gap.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  input  logic [3:0] amountBits,
  input  logic       parity,
  input  logic       even,
  input  logic       stop,
  input  logic       handshake,
  input  logic       cts,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam bit SINGLE_CLK = (CLKS_PER_BIT == 1);

  uart_state_e state_q;
  logic        tx_q;
  logic        busy_q;
  logic        done_q;
  logic [7:0]  shadow_q;
  logic [2:0]  bit_idx_q;
  logic [2:0]  last_idx_q;
  logic        stop_cnt_q;
  logic        two_stop_q;

  logic        tick;
  logic        pre_tick;
  logic        clear_c;
  logic        finish_c;
  logic [3:0]  nbits_c;
  logic [7:0]  masked_c;

`ifdef UART_TX_PARITY_EN
  logic par_en_q;
  logic par_bit_q;
  logic par_bit_c;
`else
  logic unused_par_c;
  assign unused_par_c = parity ^ even;
`endif

  // Payload with bits at or above the requested width forced to zero.
  always_comb begin
    nbits_c  = clamp_bits(amountBits);
    masked_c = '0;
    for (int i = 0; i < MAX_DATA_BITS; i++) begin
      masked_c[i] = data[i] & (4'(i) < nbits_c);
    end
  end

`ifdef UART_TX_PARITY_EN
  assign par_bit_c = even ? (^masked_c) : (~^masked_c);
`endif

  // Restart the bit timer whenever the start bit is about to begin.
  assign clear_c = (state_q == IDLE && start) || (state_q == WAIT_CTS && cts);

  // Leave STOP one cycle early; the final stop cycle is the IDLE/done cycle.
  assign finish_c = SINGLE_CLK ? 1'b1 : ((stop_cnt_q == two_stop_q) && pre_tick);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear_c),
    .tick    (tick),
    .pre_tick(pre_tick)
  );

  // Frame sequencer with registered tx/busy/done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      shadow_q   <= '0;
      bit_idx_q  <= '0;
      last_idx_q <= '0;
      stop_cnt_q <= 1'b0;
      two_stop_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            shadow_q   <= masked_c;
            last_idx_q <= 3'(nbits_c - 4'd1);
            two_stop_q <= stop;
            bit_idx_q  <= '0;
            stop_cnt_q <= 1'b0;
            busy_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_en_q   <= parity;
            par_bit_q  <= par_bit_c;
`endif
            if (handshake && !cts) begin
              state_q <= WAIT_CTS;
              tx_q    <= 1'b1;
            end else begin
              state_q <= START;
              tx_q    <= 1'b0;
            end
          end
        end
        WAIT_CTS: begin
          if (cts) begin
            state_q <= START;
            tx_q    <= 1'b0;
          end
        end
        START: begin
          if (tick) begin
            state_q   <= DATA;
            bit_idx_q <= '0;
            tx_q      <= shadow_q[0];
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx_q != last_idx_q) begin
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= shadow_q[bit_idx_q + 3'd1];
            end
`ifdef UART_TX_PARITY_EN
            else if (par_en_q) begin
              state_q <= PARITY;
              tx_q    <= par_bit_q;
            end
`endif
            else if (SINGLE_CLK && !two_stop_q) begin
              // One-cycle single stop bit: the done cycle is the stop bit.
              state_q <= IDLE;
              tx_q    <= 1'b1;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q    <= STOP;
              tx_q       <= 1'b1;
              stop_cnt_q <= 1'b0;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            if (SINGLE_CLK && !two_stop_q) begin
              state_q <= IDLE;
              tx_q    <= 1'b1;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q    <= STOP;
              tx_q       <= 1'b1;
              stop_cnt_q <= 1'b0;
            end
          end
        end
`endif
        STOP: begin
          if (finish_c) begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (tick) begin
            stop_cnt_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx with CLKS_PER_BIT=1 and =4.
// Expected line waveforms come from a frame-level model (list of bits, each
// held CLKS_PER_BIT cycles; busy high until the last cycle, done on it).
module tb_uart_tx;

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] amt;
    logic       par;
    logic       even;
    logic       stop;
    logic       hs;
  } cfg_t;

  typedef struct packed {
    cfg_t       cfg;
    logic [3:0] exp_n;
    logic       exp_par;
  } vec_t;

`ifdef UART_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       start1;
  logic       start4;
  logic [7:0] data;
  logic [3:0] amt;
  logic       par;
  logic       even;
  logic       stop;
  logic       hs;
  logic       cts;
  logic       tx1, busy1, done1;
  logic       tx4, busy4, done4;

  int errors;
  int checks;

  uart_tx #(.CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .data(data), .amountBits(amt),
    .parity(par), .even(even), .stop(stop), .handshake(hs), .cts(cts),
    .tx(tx1), .busy(busy1), .done(done1)
  );

  uart_tx #(.CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .data(data), .amountBits(amt),
    .parity(par), .even(even), .stop(stop), .handshake(hs), .cts(cts),
    .tx(tx4), .busy(busy4), .done(done4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [2:0] outs(input int sel);
    return (sel == 0) ? {tx1, busy1, done1} : {tx4, busy4, done4};
  endfunction

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: tx/busy/done got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_start(input int sel, input logic v);
    if (sel == 0) start1 = v;
    else          start4 = v;
  endtask

  task automatic apply_cfg(input cfg_t c, input logic cts_v);
    data = c.data; amt = c.amt; par = c.par; even = c.even;
    stop = c.stop; hs = c.hs; cts = cts_v;
  endtask

  // Shared inputs churn mid-frame; the frame must not notice.
  task automatic scramble();
    data = 8'($urandom); amt = 4'($urandom); par = 1'($urandom);
    even = 1'($urandom); stop = 1'($urandom); hs = 1'($urandom); cts = 1'($urandom);
  endtask

  // Reference: frame bits from the rules (width clamp, mask, parity by count).
  function automatic void model_frame(input cfg_t c, output logic [11:0] bits, output int nb);
    int n;
    int ones;
    bits = '1;
    n = (c.amt == 4'd0 || c.amt > 4'd8) ? 8 : int'(c.amt);
    bits[0] = 1'b0;
    ones = 0;
    for (int i = 0; i < n; i++) begin
      bits[1 + i] = c.data[i];
      if (c.data[i]) ones++;
    end
    nb = 1 + n;
    if (PAR_EN && c.par) begin
      bits[nb] = c.even ? (ones % 2 == 1) : (ones % 2 == 0);
      nb++;
    end
    bits[nb] = 1'b1;
    nb++;
    if (c.stop) begin
      bits[nb] = 1'b1;
      nb++;
    end
  endfunction

  // Directed vectors carry their own width and parity expectations.
  function automatic void table_frame(input vec_t v, output logic [11:0] bits, output int nb);
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < int'(v.exp_n); i++) bits[1 + i] = v.cfg.data[i];
    nb = 1 + int'(v.exp_n);
    if (PAR_EN && v.cfg.par) begin
      bits[nb] = v.exp_par;
      nb++;
    end
    nb = nb + 1 + (v.cfg.stop ? 1 : 0);
  endfunction

  task automatic drive_start(input int sel, input cfg_t c, input logic cts_v);
    @(posedge clk); #1;
    apply_cfg(c, cts_v);
    set_start(sel, 1'b1);
    @(posedge clk); #1;
    set_start(sel, 1'b0);
  endtask

  // Check every cycle of a frame that started on the previous edge.
  task automatic check_frame(input string tag, input int sel, input logic [11:0] bits,
                             input int nb, input int rp_k, input bit chain, input cfg_t nxt);
    int cpb;
    int total;
    cpb   = (sel == 0) ? 1 : 4;
    total = nb * cpb;
    for (int k = 0; k < total; k++) begin
      @(negedge clk);
      chk($sformatf("%s cyc%0d", tag, k), outs(sel),
          {bits[k / cpb], (k != total - 1), (k == total - 1)});
      scramble();
      set_start(sel, (k == rp_k) ? 1'b1 : 1'b0);
      if (chain && k == total - 1) begin
        apply_cfg(nxt, 1'b1);
        set_start(sel, 1'b1);
      end
    end
    if (chain) begin
      @(posedge clk); #1;
      set_start(sel, 1'b0);
    end else begin
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        chk($sformatf("%s idle%0d", tag, k), outs(sel), 3'b100);
        scramble();
      end
    end
  endtask

  function automatic vec_t mk(input logic [7:0] d, input logic [3:0] a, input logic p,
                              input logic e, input logic s, input logic [3:0] n, input logic ep);
    vec_t v;
    v.cfg.data = d; v.cfg.amt = a; v.cfg.par = p; v.cfg.even = e;
    v.cfg.stop = s; v.cfg.hs = 1'b0; v.exp_n = n; v.exp_par = ep;
    return v;
  endfunction

  initial begin
    vec_t        vt [8];
    cfg_t        c;
    logic [11:0] bits;
    logic [11:0] bits2;
    int          nb;
    int          nb2;
    int          sel;

    errors = 0;
    checks = 0;

    vt[0] = mk(8'hA5, 4'd8,  1'b0, 1'b0, 1'b0, 4'd8, 1'b0); // 8N1
    vt[1] = mk(8'h35, 4'd7,  1'b1, 1'b1, 1'b1, 4'd7, 1'b0); // 7E2
    vt[2] = mk(8'hFF, 4'd5,  1'b1, 1'b0, 1'b0, 4'd5, 1'b0); // 5O1, masked
    vt[3] = mk(8'h07, 4'd0,  1'b1, 1'b1, 1'b0, 4'd8, 1'b1); // width 0 -> 8
    vt[4] = mk(8'h80, 4'd12, 1'b1, 1'b0, 1'b1, 4'd8, 1'b0); // width 12 -> 8
    vt[5] = mk(8'hFE, 4'd1,  1'b1, 1'b0, 1'b0, 4'd1, 1'b1); // single bit
    vt[6] = mk(8'h5A, 4'd15, 1'b0, 1'b1, 1'b1, 4'd8, 1'b0);
    vt[7] = mk(8'hC4, 4'd3,  1'b1, 1'b1, 1'b0, 4'd3, 1'b1);

    rst = 1'b1; start1 = 1'b0; start4 = 1'b0;
    c = vt[0].cfg;
    apply_cfg(c, 1'b1);
    repeat (3) @(negedge clk);
    chk("reset dut1", outs(0), 3'b100);
    chk("reset dut4", outs(1), 3'b100);
    rst = 1'b0;

    // Directed table on both bit rates.
    for (int i = 0; i < 8; i++) begin
      table_frame(vt[i], bits, nb);
      drive_start(0, vt[i].cfg, 1'b1);
      check_frame($sformatf("vec%0d c1", i), 0, bits, nb, -1, 1'b0, vt[i].cfg);
      drive_start(1, vt[i].cfg, 1'b1);
      check_frame($sformatf("vec%0d c4", i), 1, bits, nb, -1, 1'b0, vt[i].cfg);
    end

    // Back-to-back frames: second start in the done cycle.
    table_frame(vt[0], bits, nb);
    table_frame(vt[1], bits2, nb2);
    drive_start(0, vt[0].cfg, 1'b1);
    check_frame("b2b first c1", 0, bits, nb, -1, 1'b1, vt[1].cfg);
    check_frame("b2b second c1", 0, bits2, nb2, -1, 1'b0, vt[1].cfg);
    table_frame(vt[2], bits, nb);
    table_frame(vt[3], bits2, nb2);
    drive_start(1, vt[2].cfg, 1'b1);
    check_frame("b2b first c4", 1, bits, nb, -1, 1'b1, vt[3].cfg);
    check_frame("b2b second c4", 1, bits2, nb2, -1, 1'b0, vt[3].cfg);

    // Handshake: held in wait while cts=0, start bit right after cts rises.
    c = vt[0].cfg;
    c.hs = 1'b1;
    drive_start(0, c, 1'b0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk($sformatf("hs wait%0d", k), outs(0), 3'b110);
    end
    @(posedge clk); #1;
    cts = 1'b1;
    @(posedge clk); #1;
    table_frame(vt[0], bits, nb);
    check_frame("hs frame", 0, bits, nb, -1, 1'b0, c);

    // Start re-pulsed mid-frame at 4 clocks/bit: ignored, one done.
    table_frame(vt[1], bits, nb);
    drive_start(1, vt[1].cfg, 1'b1);
    check_frame("overlap c4", 1, bits, nb, 10, 1'b0, vt[1].cfg);

    // Reset during the data bits.
    drive_start(0, vt[0].cfg, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst mid c1", outs(0), 3'b100);
    chk("rst mid c4", outs(1), 3'b100);
    @(negedge clk);
    chk("rst hold c1", outs(0), 3'b100);
    rst = 1'b0;
    @(negedge clk);
    chk("rst release c1", outs(0), 3'b100);
    table_frame(vt[0], bits, nb);
    drive_start(0, vt[0].cfg, 1'b1);
    check_frame("after rst c1", 0, bits, nb, -1, 1'b0, vt[0].cfg);

    // Random configurations against the frame model.
    for (int r = 0; r < 24; r++) begin
      sel = (r % 4 == 3) ? 1 : 0;
      c.data = 8'($urandom);
      c.amt  = 4'($urandom_range(0, 15));
      c.par  = 1'($urandom);
      c.even = 1'($urandom);
      c.stop = 1'($urandom);
      c.hs   = 1'($urandom);
      model_frame(c, bits, nb);
      drive_start(sel, c, 1'b1);
      check_frame($sformatf("rand%0d", r), sel, bits, nb, -1, 1'b0, c);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
